// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Splits a 32-bit MEM-stage load/store into two half-word accesses on a
//   16-bit external SRAM (low half first, then high half). While an access
//   runs, ready is held low to freeze the pipeline. It is released for
//   exactly one cycle (DONE) when the access completes.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   wr_en, rd_en      store / load request, held by the MEM stage until ready
//   address, wdata    byte address (word aligned) and store data
//   rdata             load data; valid while ready=1 after a read
//   ready             combinational; 0 freezes the pipeline
//   sram_addr         registered SRAM half-word address
//   sram_we_n         registered SRAM write strobe, active low
//   sram_dq_oe        registered bus drive enable for sram_dq_out
//   sram_dq_out       registered write half-word
//   sram_dq_in        read half-word from the bus
module sram_access_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_dq_oe,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [SRAM_ADDR_W-2:0] wa_q, wa_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_q, oe_d;
  logic [15:0]            dout_q, dout_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   req;
  logic                   phase_end;
  logic [31:0]            offset;
  logic [SRAM_ADDR_W-2:0] wa_new;
  logic                   unused_offset;

  assign req    = wr_en | rd_en;
  assign offset = address - 32'(BASE_ADDR);
  // Word index; upper bits are dropped so out-of-range addresses wrap.
  assign wa_new = offset[SRAM_ADDR_W:2];
  assign unused_offset = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};
  assign phase_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    we_n_d  = we_n_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    // Bus outputs are registered, so they are loaded on the edge that
    // enters each phase rather than decoded from the current state.
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = '0;
          wr_d    = wr_en;
          wa_d    = wa_new;
          wdata_d = wdata;
          addr_d  = {wa_new, 1'b0};
          we_n_d  = ~wr_en;
          oe_d    = wr_en;
          if (wr_en) dout_d = wdata[15:0];
        end
      end
      LO: begin
        if (phase_end) begin
          state_d = HI;
          cnt_d   = '0;
          addr_d  = {wa_q, 1'b1};
          if (wr_q) dout_d = wdata_q[31:16];
          else      rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HI: begin
        if (phase_end) begin
          state_d = DONE;
          cnt_d   = '0;
          we_n_d  = 1'b1;
          oe_d    = 1'b0;
          if (!wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wa_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign rdata       = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_we_n   = we_n_q;
  assign sram_dq_oe  = oe_q;
  assign sram_dq_out = dout_q;

endmodule
